// File: rtl/rr_arbiter.sv
// Round-robin arbiter: a registered one-hot grant is held until its requester releases,
// with re-arbitration in the same edge as the release.
module rr_arbiter #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] request,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [3:0]       grant_id
);

  typedef enum logic [0:0] {StIdle, StGranted} state_e;

  state_e           state_q, state_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [3:0]       grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;

  logic [WIDTH-1:0] cand;
  logic             held;
  logic             found;
  logic [3:0]       win;

  assign held = (state_q == StGranted) && request[grant_id_q];
  // The releasing requester must not win the arbitration at its own release edge.
  assign cand = (state_q == StGranted) ? (request & ~grant_q) : request;

  always_comb begin : scan
    logic [4:0] sum;
    sum   = '0;
    found = 1'b0;
    win   = '0;
    for (int unsigned off = 0; off < WIDTH; off++) begin
      sum = {1'b0, ptr_q} + 5'(off);
      if (sum >= 5'(WIDTH)) sum = sum - 5'(WIDTH);
      if (!found && cand[sum[3:0]]) begin
        found = 1'b1;
        win   = sum[3:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    if (!held) begin
      if (enable && found) begin
        state_d       = StGranted;
        grant_d       = WIDTH'(1) << win;
        grant_id_d    = win;
        grant_valid_d = 1'b1;
        ptr_d         = (win == 4'(WIDTH - 1)) ? 4'd0 : win + 4'd1;
      end else begin
        state_d       = StIdle;
        grant_d       = '0;
        grant_id_d    = '0;
        grant_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios with constant expectations plus random traffic
// compared against a round-robin reference model.
module tb_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] request = '0;
  logic [9:0] grant;
  logic       grant_valid;
  logic [3:0] grant_id;
  logic [14:0] obs;

  int n_checks = 0;
  int n_pass   = 0;
  int m_held   = -1;
  int m_ptr    = 0;

  rr_arbiter #(.WIDTH(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .request    (request),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always #5 clock = ~clock;
  assign obs = {grant, grant_valid, grant_id};

  // Reference: holder keeps the grant while requesting; otherwise scan from ptr, skipping it.
  function automatic void model_step(input logic [9:0] r, input logic e);
    int excl;
    if (m_held >= 0 && r[m_held]) return;
    excl   = m_held;
    m_held = -1;
    if (e) begin
      for (int k = 0; k < 10; k++) begin
        int i;
        i = (m_ptr + k) % 10;
        if (r[i] && i != excl) begin
          m_held = i;
          m_ptr  = (i + 1) % 10;
          break;
        end
      end
    end
  endfunction

  function automatic logic [14:0] m_outs();
    logic [9:0] g;
    g = '0;
    if (m_held < 0) return '0;
    g[m_held] = 1'b1;
    return {g, 1'b1, 4'(m_held)};
  endfunction

  task automatic drive(input logic [9:0] r, input logic e);
    @(negedge clock);
    request = r;
    enable  = e;
    @(posedge clock);
    model_step(r, e);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset   = 1'b0;
    request = '0;
    enable  = 1'b0;
    m_held  = -1;
    m_ptr   = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (obs !== 15'd0) $display("FAIL reset_outs: got %h want 0", obs);
    else n_pass++;
    n_checks++;
    if (dut.ptr_q !== 4'd0) $display("FAIL reset_ptr: got %0d want 0", dut.ptr_q);
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    drive(10'h000, 1'b1);
    n_checks++;
    if (obs !== 15'd0) $display("FAIL idle_noreq: got %h want 0", obs);
    else n_pass++;
    drive(10'h0ff, 1'b0);
    n_checks++;
    if (obs !== 15'd0 || dut.ptr_q !== 4'd0)
      $display("FAIL idle_disabled: got %h ptr %0d want 0 ptr 0", obs, dut.ptr_q);
    else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    drive(10'b00_0010_0100, 1'b1);
    n_checks++;
    if (obs !== {10'h004, 1'b1, 4'd2}) $display("FAIL basic_grant: got %h want %h",
                                                obs, {10'h004, 1'b1, 4'd2});
    else n_pass++;
    n_checks++;
    if (dut.ptr_q !== 4'd3) $display("FAIL basic_ptr: got %0d want 3", dut.ptr_q);
    else n_pass++;
    drive(10'h000, 1'b1);
    n_checks++;
    if (obs !== 15'd0) $display("FAIL basic_release: got %h want 0", obs);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic [9:0] r;
    do_reset();
    drive(10'h024, 1'b1);
    for (int c = 0; c < 4; c++) begin
      r = 10'($urandom) | 10'h024;
      drive(r, 1'b1);
      n_checks++;
      if (obs !== {10'h004, 1'b1, 4'd2}) $display("FAIL hold_cycle%0d: got %h want %h",
                                                  c, obs, {10'h004, 1'b1, 4'd2});
      else n_pass++;
    end
    drive(10'h020, 1'b1);
    n_checks++;
    if (obs !== {10'h020, 1'b1, 4'd5}) $display("FAIL hold_handover: got %h want %h",
                                                obs, {10'h020, 1'b1, 4'd5});
    else n_pass++;
    drive(10'h000, 1'b1);
  endtask

  task automatic test_wrap();
    do_reset();
    drive(10'h100, 1'b1);
    drive(10'h000, 1'b1);
    n_checks++;
    if (obs !== 15'd0 || dut.ptr_q !== 4'd9)
      $display("FAIL wrap_setup: got %h ptr %0d want 0 ptr 9", obs, dut.ptr_q);
    else n_pass++;
    drive(10'h201, 1'b1);
    n_checks++;
    if (obs !== {10'h200, 1'b1, 4'd9}) $display("FAIL wrap_first: got %h want %h",
                                                obs, {10'h200, 1'b1, 4'd9});
    else n_pass++;
    drive(10'h001, 1'b1);
    n_checks++;
    if (obs !== {10'h001, 1'b1, 4'd0} || dut.ptr_q !== 4'd1)
      $display("FAIL wrap_second: got %h ptr %0d want %h ptr 1",
               obs, dut.ptr_q, {10'h001, 1'b1, 4'd0});
    else n_pass++;
    drive(10'h000, 1'b1);
  endtask

  task automatic test_enable_block();
    do_reset();
    drive(10'h010, 1'b1);
    drive(10'h090, 1'b0);
    n_checks++;
    if (obs !== {10'h010, 1'b1, 4'd4}) $display("FAIL enable_hold: got %h want %h",
                                                obs, {10'h010, 1'b1, 4'd4});
    else n_pass++;
    drive(10'h080, 1'b0);
    n_checks++;
    if (obs !== 15'd0) $display("FAIL enable_release: got %h want 0", obs);
    else n_pass++;
    drive(10'h080, 1'b0);
    n_checks++;
    if (obs !== 15'd0) $display("FAIL enable_idle: got %h want 0", obs);
    else n_pass++;
    drive(10'h080, 1'b1);
    n_checks++;
    if (obs !== {10'h080, 1'b1, 4'd7}) $display("FAIL enable_regrant: got %h want %h",
                                                obs, {10'h080, 1'b1, 4'd7});
    else n_pass++;
    drive(10'h000, 1'b1);
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    drive(10'h040, 1'b1);
    drive(10'h040, 1'b1);
    n_checks++;
    if (obs !== {10'h040, 1'b1, 4'd6}) $display("FAIL midrst_setup: got %h want %h",
                                                obs, {10'h040, 1'b1, 4'd6});
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 15'd0 || dut.ptr_q !== 4'd0)
      $display("FAIL midrst_async: got %h ptr %0d want 0 ptr 0", obs, dut.ptr_q);
    else n_pass++;
    request = '0;
    m_held  = -1;
    m_ptr   = 0;
    @(negedge clock);
    reset = 1'b1;
    drive(10'h3ff, 1'b1);
    n_checks++;
    if (obs !== {10'h001, 1'b1, 4'd0}) $display("FAIL midrst_after: got %h want %h",
                                                obs, {10'h001, 1'b1, 4'd0});
    else n_pass++;
    drive(10'h000, 1'b1);
  endtask

  task automatic test_random();
    logic [9:0] r;
    logic       e;
    logic       prev_valid;
    logic [3:0] prev_id;
    logic       new_grant;
    int         wait_cnt [10];
    int         worst;
    do_reset();
    r          = '0;
    prev_valid = 1'b0;
    prev_id    = '0;
    worst      = 0;
    for (int i = 0; i < 10; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      r = r ^ (10'($urandom) & 10'($urandom) & 10'($urandom));
      e = ($urandom_range(9) != 0);
      drive(r, e);
      n_checks++;
      if (obs !== m_outs()) $display("FAIL rand_model cyc %0d: got %h want %h", c, obs, m_outs());
      else n_pass++;
      n_checks++;
      if ($countones(grant) > 1) $display("FAIL rand_onehot cyc %0d: got %b want <=1 bit", c, grant);
      else n_pass++;
      new_grant = grant_valid && (!prev_valid || grant_id != prev_id);
      for (int i = 0; i < 10; i++) begin
        if (!r[i] || (grant_valid && int'(grant_id) == i)) wait_cnt[i] = 0;
        else if (new_grant) wait_cnt[i]++;
        if (wait_cnt[i] > worst) worst = wait_cnt[i];
      end
      prev_valid = grant_valid;
      prev_id    = grant_id;
    end
    n_checks++;
    if (worst > 10) $display("FAIL rand_starvation: got %0d grants waited want <=10", worst);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_wrap();
    test_enable_block();
    test_reset_mid_grant();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
